ascii_to_morse: RTL and testbench

Character-serial Morse code transmitter. Accepts ASCII characters through a write port into an internal FIFO and emits them one at a time as on/off keyed Morse on a single output line, timed in dot units derived from the system clock by a programmable prescaler. Sits between a byte-producing host (UART or CPU register) and a keying output (LED, buzzer, RF key).

---
 rtl/ascii_to_morse.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ascii_to_morse.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascii_to_morse.sv
// -----------------------------------------------------------------------------
// ascii_to_morse
//
// Character-serial Morse code transmitter. A host writes ASCII characters into
// a small FIFO; an engine pops them one at a time and keys them onto a single
// output line as International Morse. Timing is in dot units of PRESCALER
// clock cycles.
//
// Parameters
//   PRESCALER  clock cycles per Morse unit (one dot), >= 2
//   DEPTH      FIFO depth in characters, power of two, >= 2
//
// Ports
//   clk        system clock, rising edge
//   arst_n     synchronous reset, active HIGH despite the name
//   write_en   write strobe, one character per cycle
//   ascii_in   character to enqueue, sampled with write_en
//   full       FIFO holds DEPTH characters (registered)
//   morse_out  keyed output, 1 = tone on (registered)
//
// Accepted characters: A-Z, a-z (sent as upper case), 0-9 and space. Anything
// else is dropped at the write port and never occupies a FIFO slot.
// -----------------------------------------------------------------------------
module ascii_to_morse #(
   parameter int PRESCALER = 50_000_000,
   parameter int DEPTH     = 16
) (
   input  logic       clk,
   input  logic       arst_n,
   input  logic       write_en,
   input  logic [7:0] ascii_in,
   output logic       full,
   output logic       morse_out
);

   localparam int UW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [UW-1:0] UNIT_LAST = UW'(PRESCALER - 1);
   localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      MARK,
      GAP
   } state_t;

   // Element code is left-aligned: bit 4 is the first element sent,
   // 1 = dash, 0 = dot. len = 0 marks "no pattern" (space / unused).
   typedef struct packed {
      logic [2:0] len;
      logic [4:0] code;
   } morse_t;

   // The port is named like an async active-low reset, but it is a
   // synchronous active-high reset.
   logic rst;
   assign rst = arst_n;

   // --------------------------------------------------------------------------
   // Character helpers
   // --------------------------------------------------------------------------
   function automatic logic [7:0] to_upper(input logic [7:0] c);
      if (c >= "a" && c <= "z") return c - 8'd32;
      return c;
   endfunction

   function automatic logic is_accepted(input logic [7:0] c);
      logic [7:0] u;
      u = to_upper(c);
      return (u >= "A" && u <= "Z") || (c >= "0" && c <= "9") || (c == " ");
   endfunction

   function automatic morse_t morse_rom(input logic [7:0] u);
      case (u)
         "A":     return '{3'd2, 5'b01000};  // .-
         "B":     return '{3'd4, 5'b10000};  // -...
         "C":     return '{3'd4, 5'b10100};  // -.-.
         "D":     return '{3'd3, 5'b10000};  // -..
         "E":     return '{3'd1, 5'b00000};  // .
         "F":     return '{3'd4, 5'b00100};  // ..-.
         "G":     return '{3'd3, 5'b11000};  // --.
         "H":     return '{3'd4, 5'b00000};  // ....
         "I":     return '{3'd2, 5'b00000};  // ..
         "J":     return '{3'd4, 5'b01110};  // .---
         "K":     return '{3'd3, 5'b10100};  // -.-
         "L":     return '{3'd4, 5'b01000};  // .-..
         "M":     return '{3'd2, 5'b11000};  // --
         "N":     return '{3'd2, 5'b10000};  // -.
         "O":     return '{3'd3, 5'b11100};  // ---
         "P":     return '{3'd4, 5'b01100};  // .--.
         "Q":     return '{3'd4, 5'b11010};  // --.-
         "R":     return '{3'd3, 5'b01000};  // .-.
         "S":     return '{3'd3, 5'b00000};  // ...
         "T":     return '{3'd1, 5'b10000};  // -
         "U":     return '{3'd3, 5'b00100};  // ..-
         "V":     return '{3'd4, 5'b00010};  // ...-
         "W":     return '{3'd3, 5'b01100};  // .--
         "X":     return '{3'd4, 5'b10010};  // -..-
         "Y":     return '{3'd4, 5'b10110};  // -.--
         "Z":     return '{3'd4, 5'b11000};  // --..
         "0":     return '{3'd5, 5'b11111};  // -----
         "1":     return '{3'd5, 5'b01111};  // .----
         "2":     return '{3'd5, 5'b00111};  // ..---
         "3":     return '{3'd5, 5'b00011};  // ...--
         "4":     return '{3'd5, 5'b00001};  // ....-
         "5":     return '{3'd5, 5'b00000};  // .....
         "6":     return '{3'd5, 5'b10000};  // -....
         "7":     return '{3'd5, 5'b11000};  // --...
         "8":     return '{3'd5, 5'b11100};  // ---..
         "9":     return '{3'd5, 5'b11110};  // ----.
         default: return '{3'd0, 5'b00000};
      endcase
   endfunction

   // --------------------------------------------------------------------------
   // FIFO
   // --------------------------------------------------------------------------
   logic [7:0]    fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   logic          push;
   logic          pop;
   logic          empty;

   state_t        state;
   state_t        state_next;

   assign empty = (count == '0);
   // A write while full is dropped even if the engine pops in the same cycle.
   assign push  = write_en && !full && is_accepted(ascii_in);
   assign pop   = (state == IDLE) && !empty;

   // NOTE: storage has no reset; occupancy is tracked by the pointers and
   // count, so stale entries are never read.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= ascii_in;
   end

   // NOTE: every default is assigned first so no path leaves a variable
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         full  <= (count_next == CNT_FULL);
      end
   end

   // Head-of-queue character, decoded for the engine.
   logic [7:0] head_char;
   morse_t     head_sym;
   logic       head_space;

   assign head_char  = to_upper(fifo_mem[rd_ptr]);
   assign head_sym   = morse_rom(head_char);
   assign head_space = (head_char == " ");

   // --------------------------------------------------------------------------
   // Engine timing
   // --------------------------------------------------------------------------
   logic [UW-1:0] unit_cnt;    // cycle within the current unit
   logic [2:0]    units_left;  // units remaining in the current span
   logic [2:0]    elems_left;  // elements not yet fully sent
   logic [4:0]    pattern;     // bit 4 = current / next element
   logic          unit_end;
   logic          span_done;
   logic          morse_d;

   assign unit_end  = (unit_cnt == UNIT_LAST);
   assign span_done = unit_end && (units_left == 3'd1);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (pop) state_next = head_space ? GAP : MARK;
         MARK:    if (span_done) state_next = GAP;
         GAP:     if (span_done) state_next = (elems_left == 3'd0) ? IDLE : MARK;
         default: state_next = IDLE;
      endcase
   end

   // Output logic; registered below so the key line is glitch-free.
   always_comb begin
      morse_d = (state == MARK);
   end

   always_ff @(posedge clk) begin
      if (rst) morse_out <= 1'b0;
      else     morse_out <= morse_d;
   end

   // Span counters, reloaded on every state entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         unit_cnt   <= '0;
         units_left <= '0;
         elems_left <= '0;
         pattern    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  if (head_space) begin
                     // The IDLE cycle that pops a space already counts as low
                     // time, so its 4-unit gap starts one cycle into the unit.
                     // This keeps each space at exactly 4 units.
                     pattern    <= '0;
                     elems_left <= 3'd0;
                     units_left <= 3'd4;
                     unit_cnt   <= UW'(1);
                  end else begin
                     pattern    <= head_sym.code;
                     elems_left <= head_sym.len;
                     units_left <= head_sym.code[4] ? 3'd3 : 3'd1;
                     unit_cnt   <= '0;
                  end
               end
            end
            MARK: begin
               if (span_done) begin
                  unit_cnt   <= '0;
                  units_left <= (elems_left == 3'd1) ? 3'd3 : 3'd1;
                  elems_left <= elems_left - 3'd1;
                  pattern    <= pattern << 1;
               end else if (unit_end) begin
                  unit_cnt   <= '0;
                  units_left <= units_left - 3'd1;
               end else begin
                  unit_cnt   <= unit_cnt + 1'b1;
               end
            end
            GAP: begin
               if (span_done) begin
                  unit_cnt   <= '0;
                  units_left <= pattern[4] ? 3'd3 : 3'd1;
               end else if (unit_end) begin
                  unit_cnt   <= '0;
                  units_left <= units_left - 3'd1;
               end else begin
                  unit_cnt   <= unit_cnt + 1'b1;
               end
            end
            default: begin
               unit_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ascii_to_morse.sv
// -----------------------------------------------------------------------------
// tb_ascii_to_morse
//
// Scoreboard bench for ascii_to_morse. Stimulus writes characters and pushes
// the expected pulse train (low time before each pulse, pulse width, and the
// absolute rise cycle for the first pulse after idle) into a queue. A monitor
// measures run lengths on morse_out and pops/compares on every rising edge.
// -----------------------------------------------------------------------------
module tb_ascii_to_morse;

   localparam int P     = 4;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       arst_n;
   logic       write_en;
   logic [7:0] ascii_in;
   logic       full;
   logic       morse_out;

   always #5 clk = ~clk;

   ascii_to_morse #(
      .PRESCALER(P),
      .DEPTH    (DEPTH)
   ) dut (
      .clk      (clk),
      .arst_n   (arst_n),
      .write_en (write_en),
      .ascii_in (ascii_in),
      .full     (full),
      .morse_out(morse_out)
   );

   typedef struct {
      int rise_at;  // absolute cycle of the rise, -1 = don't care
      int low;      // low cycles before the pulse, -1 = don't care
      int high;     // pulse width in cycles
   } pulse_t;

   pulse_t sb[$];
   int     n_checks        = 0;
   int     n_pass          = 0;
   int     cyc             = 0;
   int     pending_low     = -1;
   int     pulses_expected = 0;
   int     pulses_seen     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
   endtask

   // Hand-written Morse table, independent of the RTL encoding.
   function automatic string morse_of(input logic [7:0] c);
      logic [7:0] u;
      u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
      case (u)
         "A": return ".-";    "B": return "-...";  "C": return "-.-.";
         "D": return "-..";   "E": return ".";     "F": return "..-.";
         "G": return "--.";   "H": return "....";  "I": return "..";
         "J": return ".---";  "K": return "-.-";   "L": return ".-..";
         "M": return "--";    "N": return "-.";    "O": return "---";
         "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
         "S": return "...";   "T": return "-";     "U": return "..-";
         "V": return "...-";  "W": return ".--";   "X": return "-..-";
         "Y": return "-.--";  "Z": return "--..";
         "0": return "-----"; "1": return ".----"; "2": return "..---";
         "3": return "...--"; "4": return "....-"; "5": return ".....";
         "6": return "-...."; "7": return "--..."; "8": return "---..";
         "9": return "----.";
         default: return "";
      endcase
   endfunction

   // Push the expected pulses of one accepted character. trunc_high > 0
   // replaces the pulse width (used when reset cuts a pulse short).
   task automatic expect_char(input logic [7:0] c, input int rise_at, input int trunc_high);
      string m;
      pulse_t e;
      if (c == " ") begin
         if (pending_low >= 0) pending_low += 4 * P;
         return;
      end
      m = morse_of(c);
      for (int i = 0; i < m.len(); i++) begin
         e.rise_at = (i == 0) ? rise_at : -1;
         e.low     = (i == 0) ? pending_low : P;
         e.high    = (m[i] == "-") ? 3 * P : P;
         if (trunc_high > 0) e.high = trunc_high;
         sb.push_back(e);
         pulses_expected++;
      end
      pending_low = 3 * P + 1;
   endtask

   // Drive one write cycle; wr_edge is the clock edge that samples it.
   task automatic put(input logic [7:0] c, input logic en, output int wr_edge);
      @(negedge clk);
      write_en = en;
      ascii_in = c;
      wr_edge  = cyc + 1;
   endtask

   task automatic idle_bus();
      @(negedge clk);
      write_en = 1'b0;
      ascii_in = 8'h00;
   endtask

   task automatic send(input string s, input bit from_idle);
      int e;
      for (int i = 0; i < s.len(); i++) begin
         put(s[i], 1'b1, e);
         expect_char(s[i], (from_idle && i == 0) ? e + 2 : -1, 0);
      end
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((sb.size() != 0 || morse_out === 1'b1) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", sb.size(), 0);
      repeat (3 * P + 4) @(negedge clk);
      pending_low = -1;
   endtask

   // ---------------------------------------------------------------- monitor
   logic   mon_lvl    = 1'b0;
   int     mon_run    = 0;
   bit     have_entry = 1'b0;
   pulse_t cur;

   always @(negedge clk) begin
      logic lvl;
      lvl = (morse_out === 1'b1);
      if (lvl != mon_lvl) begin
         if (lvl) begin
            pulses_seen++;
            if (sb.size() == 0) begin
               check("unexpected_pulse", pulses_seen, pulses_expected);
               have_entry = 1'b0;
            end else begin
               cur = sb.pop_front();
               have_entry = 1'b1;
               if (cur.low >= 0)     check("low_len", mon_run, cur.low);
               if (cur.rise_at >= 0) check("rise_cycle", cyc, cur.rise_at);
            end
         end else if (have_entry) begin
            check("high_len", mon_run, cur.high);
            have_entry = 1'b0;
         end
         mon_run = 1;
         mon_lvl = lvl;
      end else begin
         mon_run++;
      end
   end

   // --------------------------------------------------------------- watchdog
   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // --------------------------------------------------------------- stimulus
   initial begin
      int    e;
      int    n;
      string s17;

      arst_n   = 1'b1;
      write_en = 1'b0;
      ascii_in = 8'h00;

      // Reset held for 5 cycles, then no activity with write_en low.
      repeat (5) @(negedge clk);
      check("reset_morse_out", int'(morse_out), 0);
      check("reset_full", int'(full), 0);
      arst_n = 1'b0;
      repeat (20) @(negedge clk);
      check("idle_morse_out", int'(morse_out), 0);
      check("idle_full", int'(full), 0);

      // Single 'E' (one dot), then a lowercase 't' (one dash).
      send("E", 1'b1);
      idle_bus();
      wait_drain(200);
      send("t", 1'b1);
      idle_bus();
      wait_drain(200);

      // 0x00 dropped, "CARS", more rejects, then " ARE red".
      put(8'h00, 1'b1, e);
      send("CARS", 1'b1);
      put(8'h00, 1'b1, e);
      put(8'h00, 1'b0, e);
      put(8'h00, 1'b0, e);
      put("@", 1'b1, e);   // just below 'A'
      put("[", 1'b1, e);   // just above 'Z'
      put(8'h60, 1'b1, e); // just below 'a'
      put("{", 1'b1, e);   // just above 'z'
      put("/", 1'b1, e);   // just below '0'
      put(":", 1'b1, e);   // just above '9'
      put(8'hFF, 1'b1, e);
      send(" ARE red", 1'b0);
      idle_bus();
      wait_drain(4000);

      // Fill: '0' keeps the engine busy while 17 characters are written.
      put("0", 1'b1, e);
      expect_char("0", e + 2, 0);
      idle_bus();
      repeat (3) @(negedge clk);
      s17 = "ETIANMSURWDKGOHVQ";
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         if (i > 0) check("full_after_write", int'(full), (i >= 16) ? 1 : 0);
         write_en = 1'b1;
         ascii_in = s17[i];
         if (i < 16) expect_char(s17[i], -1, 0);
      end
      @(negedge clk);
      write_en = 1'b0;
      ascii_in = 8'h00;
      check("full_after_17th", int'(full), 1);
      n = 0;
      while (full === 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("full_falls_after_pop", int'(full), 0);
      wait_drain(4000);

      // Reset during the dash of 'T' with 'A' queued: 'A' is never sent.
      put("T", 1'b1, e);
      expect_char("T", e + 2, 5);
      put("A", 1'b1, e);
      idle_bus();
      pending_low = -1;
      n = 0;
      while (morse_out !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t_dash_started", int'(morse_out), 1);
      repeat (4) @(negedge clk);
      arst_n = 1'b1;
      @(negedge clk);
      check("midchar_reset_morse_out", int'(morse_out), 0);
      check("midchar_reset_full", int'(full), 0);
      arst_n = 1'b0;
      repeat (100) @(negedge clk);
      check("after_reset_silent", int'(morse_out), 0);
      check("after_reset_queue", sb.size(), 0);

      // '5' then '0'.
      send("50", 1'b1);
      idle_bus();
      wait_drain(1000);

      check("pulse_count", pulses_seen, pulses_expected);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
